trdb_packet_scheduler: RTL and testbench
========================================

Name: trdb_packet_scheduler

Overview:
- Sequencing controller for the trace encoder packet datapath.
- Collects packet-emission requests from the instruction-qualification logic: trap, first/sync, branch-map-full and uninferable-address events.
- Runs an internal resync counter and arbitrates pending requests by fixed priority.
- Presents one packet descriptor at a time to the packet builder/encapsulator over a valid/ready handshake.

Parameters:
- RESYNC_MAX, 16, number of retired instructions between forced format-3 resync packets (>=2).
- CNTW, 16, width of the resync counter and of the optional drop counter (must satisfy 2**CNTW > RESYNC_MAX).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- trace_enable_i  in  1  tracing enabled; low flushes pending requests and the counter
- iretired_i  in  1  one instruction retired this cycle
- req_exc_i  in  1  exception/interrupt occurred (format 3, subformat 1)
- req_sync_i  in  1  first qualified instr / privilege change (format 3, subformat 0)
- req_bmap_i  in  1  branch map full (format 1)
- req_addr_i  in  1  uninferable discontinuity (format 2)
- pkt_valid_o  out  1  descriptor valid
- pkt_ready_i  in  1  packet builder accepts descriptor
- pkt_format_o  out  2  01 = format 1, 10 = format 2, 11 = format 3
- pkt_subformat_o  out  2  00 = sync, 01 = trap; 00 for formats 1/2
- pkt_resync_o  out  1  descriptor was produced by the resync counter
- pending_o  out  5  pending flags {addr, bmap, resync, sync, exc} (debug)

Behaviour:
- Reset (rst_i high at a clock edge):
  - All pending flags, the counter and all outputs go to 0; FSM enters IDLE.
  - Reset takes effect mid-handshake too: valid drops the next cycle and no handshake completes.
- Request capture:
  - Each req_*_i high at an edge sets its pending flag; requests are level-sampled per cycle.
  - A request for an already-pending type merges; it is not queued twice.
  - A request arriving in the same cycle its own type's handshake completes leaves the flag set, so the request is not lost.
- Resync counter:
  - When trace_enable_i=1 and iretired_i=1, the counter increments.
  - When it would reach RESYNC_MAX, it wraps to 0 and sets resync pending.
  - The counter clears to 0 on completion of any format-3 handshake (sync, exc or resync).
- Priority, highest first: exc > sync > resync > bmap > addr.
- FSM:
  - IDLE: if trace_enable_i and (pending | incoming req) is nonzero, latch the winner of the combined set into the descriptor registers, go to EMIT. pkt_valid_o is high from the next cycle, so request-to-valid latency is 1 cycle.
  - EMIT: pkt_valid_o=1. Descriptor outputs are held stable until pkt_ready_i=1; a higher-priority arrival does not pre-empt.
  - On pkt_valid_o & pkt_ready_i: clear the winner's pending flag and return to IDLE. This gives one bubble cycle between consecutive descriptors, so the maximum rate is one descriptor per 2 cycles.
- Disable (trace_enable_i=0):
  - Pending flags and counter clear each cycle and new requests are ignored.
  - A descriptor already in EMIT stays valid until its handshake completes; no truncation.
- Outputs are driven only from registers; no combinational path from req_*_i to pkt_*_o.
- The format-3 resync descriptor is format 11, subformat 00, with pkt_resync_o=1. pkt_resync_o is 0 for every other descriptor.

Optional Feature:
- Macro: TRDB_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o [CNTW-1:0].
  - drop_cnt_o increments once per cycle in which at least one req_*_i (or a resync wrap) hits an already-set pending flag and the request is merged.
  - Saturates at all-ones and clears on reset only.
- Undefined: no port and no counter; merged requests are silently absorbed.

Test Plan:
- Reset, then req_bmap_i pulse at cycle 5 with pkt_ready_i=1 -> pkt_valid_o high at cycle 6 with format 01, subformat 00; valid low at cycle 7.
- req_addr_i and req_exc_i pulsed together with ready=0 for 3 cycles, then ready=1:
  - First descriptor is format 11/sub 01, held stable for all 3 stalled cycles.
  - After the bubble, the next descriptor is format 10.
- RESYNC_MAX=16, iretired_i=1 continuously, no other requests -> descriptor format 11/sub 00/pkt_resync_o=1 valid 1 cycle after the 16th retirement; repeats every 16 retirements.
- Resync counter at 10, req_sync_i handshake completes -> counter returns to 0; the next resync fires 16 retirements later, not 6.
- req_addr_i in the same cycle as a format-10 handshake -> a second format-10 descriptor follows after one bubble.
- trace_enable_i dropped while in EMIT with bmap pending -> current descriptor completes on ready; bmap is discarded; pkt_valid_o stays 0 afterward. With TRDB_DROP_CNT_EN, req_bmap_i held for 4 cycles while stalled -> drop_cnt_o = 3.

Source files
------------

// File: rtl/trdb_packet_scheduler.sv
// ---------------------------------------------------------------------------
// trdb_packet_scheduler
//
// Sequencing controller for the trace encoder packet datapath. It collects
// packet-emission requests (trap, sync, branch-map-full, uninferable address),
// runs a resync counter that forces a format-3 sync packet every RESYNC_MAX
// retired instructions, and hands one packet descriptor at a time to the
// packet builder over a valid/ready handshake.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   trace_enable_i   tracing enabled; low flushes pending requests and counter
//   iretired_i       one instruction retired this cycle
//   req_exc_i        exception/interrupt        -> format 3, subformat 1
//   req_sync_i       first instr / priv change  -> format 3, subformat 0
//   req_bmap_i       branch map full            -> format 1
//   req_addr_i       uninferable discontinuity  -> format 2
//   pkt_valid_o      descriptor valid
//   pkt_ready_i      packet builder accepts descriptor
//   pkt_format_o     01 = fmt 1, 10 = fmt 2, 11 = fmt 3
//   pkt_subformat_o  00 = sync, 01 = trap (00 for formats 1/2)
//   pkt_resync_o     descriptor came from the resync counter
//   pending_o        pending flags {addr, bmap, resync, sync, exc}
//   drop_cnt_o       (TRDB_DROP_CNT_EN only) saturating count of cycles in
//                    which a request merged into an already-pending flag
//
// Optional feature macro: TRDB_DROP_CNT_EN
// ---------------------------------------------------------------------------
module trdb_packet_scheduler #(
  parameter int RESYNC_MAX = 16,
  parameter int CNTW       = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trace_enable_i,
  input  logic            iretired_i,
  input  logic            req_exc_i,
  input  logic            req_sync_i,
  input  logic            req_bmap_i,
  input  logic            req_addr_i,
  output logic            pkt_valid_o,
  input  logic            pkt_ready_i,
  output logic [1:0]      pkt_format_o,
  output logic [1:0]      pkt_subformat_o,
  output logic            pkt_resync_o,
  output logic [4:0]      pending_o
`ifdef TRDB_DROP_CNT_EN
  ,
  output logic [CNTW-1:0] drop_cnt_o
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Bit positions inside the pending / winner vectors, lowest = highest priority
  localparam int EXC   = 0;
  localparam int SYNC  = 1;
  localparam int RSYNC = 2;
  localparam int BMAP  = 3;
  localparam int ADDR  = 4;

  localparam logic [4:0]      FMT3_MASK = 5'b00111;
  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(RESYNC_MAX - 1);

  // Fixed-priority pick: one-hot of the highest-priority set bit
  function automatic logic [4:0] pick_winner(input logic [4:0] set_v);
    logic [4:0] win_v;
    win_v = 5'b00000;
    if (set_v[EXC]) begin
      win_v[EXC] = 1'b1;
    end else if (set_v[SYNC]) begin
      win_v[SYNC] = 1'b1;
    end else if (set_v[RSYNC]) begin
      win_v[RSYNC] = 1'b1;
    end else if (set_v[BMAP]) begin
      win_v[BMAP] = 1'b1;
    end else if (set_v[ADDR]) begin
      win_v[ADDR] = 1'b1;
    end else begin
      win_v = 5'b00000;
    end
    return win_v;
  endfunction

  // Descriptor for a one-hot winner: {format[1:0], subformat[1:0], resync}
  function automatic logic [4:0] decode_desc(input logic [4:0] win_v);
    logic [4:0] desc_v;
    case (win_v)
      5'b00001: desc_v = {2'b11, 2'b01, 1'b0};
      5'b00010: desc_v = {2'b11, 2'b00, 1'b0};
      5'b00100: desc_v = {2'b11, 2'b00, 1'b1};
      5'b01000: desc_v = {2'b01, 2'b00, 1'b0};
      5'b10000: desc_v = {2'b10, 2'b00, 1'b0};
      default:  desc_v = {2'b00, 2'b00, 1'b0};
    endcase
    return desc_v;
  endfunction

  state_t          state_r, state_s;
  logic            valid_r, valid_s;
  logic [1:0]      fmt_r, fmt_s;
  logic [1:0]      sub_r, sub_s;
  logic            rsync_r, rsync_s;
  logic [4:0]      win_r, win_s;
  logic [4:0]      pending_r, pending_s;
  logic [CNTW-1:0] cnt_r, cnt_s;
  logic [CNTW-1:0] cnt_base_s;
  logic [4:0]      in_s;
  logic [4:0]      clr_s;
  logic [4:0]      cand_s;
  logic            hs_s;
  logic            hs_fmt3_s;
  logic            wrap_s;

  // Next-state, counter, pending-flag and descriptor computation
  always_comb begin
    state_s   = state_r;
    valid_s   = valid_r;
    fmt_s     = fmt_r;
    sub_s     = sub_r;
    rsync_s   = rsync_r;
    win_s     = win_r;
    wrap_s    = 1'b0;

    hs_s      = valid_r & pkt_ready_i;
    hs_fmt3_s = hs_s & (|(win_r & FMT3_MASK));
    clr_s     = hs_s ? win_r : 5'b00000;

    // A completed format-3 handshake restarts the count; a retirement in
    // the same cycle still counts as the first one of the new interval.
    cnt_base_s = hs_fmt3_s ? CNT_ZERO : cnt_r;
    if (!trace_enable_i) begin
      cnt_s = CNT_ZERO;
    end else if (iretired_i) begin
      if (cnt_base_s == CNT_LAST) begin
        cnt_s  = CNT_ZERO;
        wrap_s = 1'b1;
      end else begin
        cnt_s  = cnt_base_s + CNT_ONE;
      end
    end else begin
      cnt_s = cnt_base_s;
    end

    if (trace_enable_i) begin
      in_s = {req_addr_i, req_bmap_i, wrap_s, req_sync_i, req_exc_i};
    end else begin
      in_s = 5'b00000;
    end

    // Clear the served flag first so a same-cycle request of that type re-arms it
    if (trace_enable_i) begin
      pending_s = (pending_r & ~clr_s) | in_s;
    end else begin
      pending_s = 5'b00000;
    end

    cand_s = pending_r | in_s;

    case (state_r)
      IDLE: begin
        if (trace_enable_i && (cand_s != 5'b00000)) begin
          win_s                    = pick_winner(cand_s);
          {fmt_s, sub_s, rsync_s}  = decode_desc(pick_winner(cand_s));
          valid_s                  = 1'b1;
          state_s                  = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        // Descriptor is held; later higher-priority arrivals wait their turn
        if (pkt_ready_i) begin
          valid_s = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, descriptor, pending and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      valid_r   <= 1'b0;
      fmt_r     <= 2'b00;
      sub_r     <= 2'b00;
      rsync_r   <= 1'b0;
      win_r     <= 5'b00000;
      pending_r <= 5'b00000;
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      valid_r   <= valid_s;
      fmt_r     <= fmt_s;
      sub_r     <= sub_s;
      rsync_r   <= rsync_s;
      win_r     <= win_s;
      pending_r <= pending_s;
      cnt_r     <= cnt_s;
    end
  end

  assign pkt_valid_o     = valid_r;
  assign pkt_format_o    = fmt_r;
  assign pkt_subformat_o = sub_r;
  assign pkt_resync_o    = rsync_r;
  assign pending_o       = pending_r;

`ifdef TRDB_DROP_CNT_EN
  logic            merge_s;
  logic [CNTW-1:0] drop_cnt_r;

  // A request hitting a flag that stays set this cycle is a merge
  assign merge_s = |(in_s & pending_r & ~clr_s);

  // Saturating merge counter, cleared by reset only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_r <= CNT_ZERO;
    end else if (merge_s && (drop_cnt_r != {CNTW{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + CNT_ONE;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
module tb_trdb_packet_scheduler;

  localparam int RESYNC_MAX = 16;
  localparam int CNTW       = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic trace_enable_i = 1'b1;
  logic iretired_i = 1'b0;
  logic req_exc_i = 1'b0;
  logic req_sync_i = 1'b0;
  logic req_bmap_i = 1'b0;
  logic req_addr_i = 1'b0;
  logic pkt_ready_i = 1'b0;
  logic pkt_valid_o;
  logic [1:0] pkt_format_o;
  logic [1:0] pkt_subformat_o;
  logic pkt_resync_o;
  logic [4:0] pending_o;
`ifdef TRDB_DROP_CNT_EN
  logic [CNTW-1:0] drop_cnt_o;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  trdb_packet_scheduler #(.RESYNC_MAX(RESYNC_MAX), .CNTW(CNTW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trace_enable_i(trace_enable_i),
    .iretired_i(iretired_i), .req_exc_i(req_exc_i), .req_sync_i(req_sync_i),
    .req_bmap_i(req_bmap_i), .req_addr_i(req_addr_i),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
    .pkt_resync_o(pkt_resync_o), .pending_o(pending_o)
`ifdef TRDB_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  // ---------------- reference model (kinds: 0 exc,1 sync,2 resync,3 bmap,4 addr)
  int   m_cnt;
  bit   m_pend[5];
  bit   m_busy;
  int   m_kind;
  logic [1:0] m_fmt, m_sub;
  bit   m_rs;
  int   m_drop;

  task automatic model_step();
    bit req[5];
    bit nxt[5];
    bit hs, f3, wrap, merged, still, found;
    int base;
    if (rst_i) begin
      m_cnt = 0; m_busy = 0; m_kind = 0; m_fmt = 2'b00; m_sub = 2'b00; m_rs = 0; m_drop = 0;
      for (int i = 0; i < 5; i++) m_pend[i] = 0;
    end else begin
      hs = m_busy && pkt_ready_i;
      f3 = hs && (m_kind <= 2);
      wrap = 0;
      if (!trace_enable_i) begin
        m_cnt = 0;
      end else begin
        base = f3 ? 0 : m_cnt;
        if (iretired_i) begin
          base = base + 1;
          if (base == RESYNC_MAX) begin base = 0; wrap = 1; end
        end
        m_cnt = base;
      end
      req = '{req_exc_i, req_sync_i, wrap, req_bmap_i, req_addr_i};
      merged = 0;
      for (int i = 0; i < 5; i++) begin
        still = m_pend[i] && !(hs && m_kind == i);
        if (trace_enable_i && req[i] && still) merged = 1;
        nxt[i] = trace_enable_i && (still || req[i]);
      end
      if (m_busy) begin
        if (pkt_ready_i) m_busy = 0;
      end else if (trace_enable_i) begin
        found = 0;
        for (int i = 0; i < 5; i++) begin
          if (!found && nxt[i]) begin
            found = 1; m_busy = 1; m_kind = i;
            m_rs = (i == 2);
            m_fmt = (i <= 2) ? 2'b11 : ((i == 3) ? 2'b01 : 2'b10);
            m_sub = (i == 0) ? 2'b01 : 2'b00;
          end
        end
      end
      for (int i = 0; i < 5; i++) m_pend[i] = nxt[i];
      if (merged && m_drop < (2 ** CNTW) - 1) m_drop = m_drop + 1;
    end
  endtask

  function automatic logic [10:0] exp_vec();
    return {m_busy, m_fmt, m_sub, m_rs, m_pend[4], m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {pkt_valid_o, pkt_format_o, pkt_subformat_o, pkt_resync_o, pending_o};
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    trace_enable_i = 1'b1; iretired_i = 1'b0; pkt_ready_i = 1'b0;
    req_exc_i = 1'b0; req_sync_i = 1'b0; req_bmap_i = 1'b0; req_addr_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    idle_inputs();
    pkt_ready_i = 1'b1; req_bmap_i = 1'b1;
    cycle();
    rst_i = 1'b1;
    cycle();
    vec_cnt++;
    if (obs_vec() !== 11'd0) begin
      err_cnt++; $display("FAIL reset: got %b want %b", obs_vec(), 11'd0);
    end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  task automatic test_bmap_single();
    do_reset();
    pkt_ready_i = 1'b1;
    for (int c = 1; c < 5; c++) cycle();
    req_bmap_i = 1'b1;
    cycle();
    vec_cnt++;
    if (obs_vec() !== 11'b1_01_00_0_01000) begin
      err_cnt++; $display("FAIL bmap_valid: got %b want %b", obs_vec(), 11'b1_01_00_0_01000);
    end
    req_bmap_i = 1'b0;
    cycle();
    vec_cnt++;
    if (obs_vec() !== exp_vec() || pkt_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL bmap_drop: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_addr_i = 1'b1; req_exc_i = 1'b1;
    cycle();
    req_addr_i = 1'b0; req_exc_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vec_cnt++;
      if ({pkt_valid_o, pkt_format_o, pkt_subformat_o, pkt_resync_o} !== 6'b1_11_01_0) begin
        err_cnt++; $display("FAIL stall_hold%0d: got %b want %b", c,
          {pkt_valid_o, pkt_format_o, pkt_subformat_o, pkt_resync_o}, 6'b1_11_01_0);
      end
      if (c == 2) pkt_ready_i = 1'b1;
      cycle();
    end
    vec_cnt++;
    if (pkt_valid_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      err_cnt++; $display("FAIL stall_bubble: got %b want %b", obs_vec(), exp_vec());
    end
    cycle();
    vec_cnt++;
    if ({pkt_valid_o, pkt_format_o} !== 3'b1_10 || obs_vec() !== exp_vec()) begin
      err_cnt++; $display("FAIL stall_second: got %b want %b", obs_vec(), exp_vec());
    end
    cycle();
  endtask

  task automatic test_resync();
    int seen;
    do_reset();
    seen = 0;
    pkt_ready_i = 1'b1; iretired_i = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      vec_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++; $display("FAIL resync_c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
      if (pkt_valid_o && pkt_resync_o && pkt_format_o == 2'b11) seen++;
    end
    vec_cnt++;
    if (seen !== 2) begin
      err_cnt++; $display("FAIL resync_count: got %0d want %0d", seen, 2);
    end
  endtask

  task automatic test_sync_clears_counter();
    int hs_edge, rs_edge;
    do_reset();
    pkt_ready_i = 1'b1; iretired_i = 1'b1;
    hs_edge = -1; rs_edge = -1;
    for (int c = 1; c <= 10; c++) cycle();
    req_sync_i = 1'b1;
    cycle();
    req_sync_i = 1'b0;
    for (int c = 12; c <= 40; c++) begin
      if (pkt_valid_o && !pkt_resync_o && hs_edge < 0) hs_edge = c;
      cycle();
      vec_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++; $display("FAIL syncclr_c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
      if (pkt_valid_o && pkt_resync_o && rs_edge < 0) rs_edge = c;
    end
    vec_cnt++;
    if (rs_edge !== hs_edge + RESYNC_MAX - 1) begin
      err_cnt++; $display("FAIL syncclr_edge: got %0d want %0d", rs_edge, hs_edge + RESYNC_MAX - 1);
    end
  endtask

  task automatic test_back_to_back();
    int n10;
    do_reset();
    n10 = 0;
    pkt_ready_i = 1'b1; req_addr_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) req_addr_i = 1'b0;
      cycle();
      vec_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++; $display("FAIL b2b_c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
      if (pkt_valid_o && pkt_format_o == 2'b10) n10++;
    end
    vec_cnt++;
    if (n10 !== 2) begin
      err_cnt++; $display("FAIL b2b_count: got %0d want %0d", n10, 2);
    end
  endtask

  task automatic test_disable();
    do_reset();
    req_exc_i = 1'b1;
    cycle();
    req_exc_i = 1'b0; req_bmap_i = 1'b1;
    cycle();
    req_bmap_i = 1'b0; trace_enable_i = 1'b0;
    cycle();
    vec_cnt++;
    if (obs_vec() !== 11'b1_11_01_0_00000) begin
      err_cnt++; $display("FAIL dis_hold: got %b want %b", obs_vec(), 11'b1_11_01_0_00000);
    end
    pkt_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 4) begin
        trace_enable_i = 1'b1; req_bmap_i = 1'b0; req_addr_i = 1'b0;
      end else begin
        req_bmap_i = 1'($urandom_range(0, 1)); req_addr_i = 1'($urandom_range(0, 1));
      end
      cycle();
      vec_cnt++;
      if (pkt_valid_o !== 1'b0 || obs_vec() !== exp_vec()) begin
        err_cnt++; $display("FAIL dis_c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

`ifdef TRDB_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    req_bmap_i = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    req_bmap_i = 1'b0;
    vec_cnt++;
    if (drop_cnt_o !== CNTW'(3) || int'(drop_cnt_o) !== m_drop) begin
      err_cnt++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt_o, 3);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_i          = ($urandom_range(0, 99) == 0);
      trace_enable_i = ($urandom_range(0, 19) != 0);
      iretired_i     = 1'($urandom_range(0, 1));
      pkt_ready_i    = ($urandom_range(0, 2) != 0);
      req_exc_i      = ($urandom_range(0, 15) == 0);
      req_sync_i     = ($urandom_range(0, 15) == 0);
      req_bmap_i     = ($urandom_range(0, 5) == 0);
      req_addr_i     = ($urandom_range(0, 5) == 0);
      cycle();
      vec_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++; $display("FAIL rand_c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
`ifdef TRDB_DROP_CNT_EN
      vec_cnt++;
      if (int'(drop_cnt_o) !== m_drop) begin
        err_cnt++; $display("FAIL rand_drop_c%0d: got %0d want %0d", c, drop_cnt_o, m_drop);
      end
`endif
    end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    #2;
    cycle();
    rst_i = 1'b0;
    test_reset();
    test_bmap_single();
    test_stall();
    test_resync();
    test_sync_clears_counter();
    test_back_to_back();
    test_disable();
`ifdef TRDB_DROP_CNT_EN
    test_drop_cnt();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
